// File: rtl/rgb_to_gray_pkg.sv
// Shared constants and types for the RGB-to-luma stage in front of the
// binarisation LUT.
package rgb_to_gray_pkg;

   localparam logic [7:0]  COEF_R     = 8'd77;
   localparam logic [7:0]  COEF_G     = 8'd150;
   localparam logic [7:0]  COEF_B     = 8'd29;
   localparam logic [15:0] ROUND      = 16'd128;
   localparam int          PIPE_DEPTH = 2;

   typedef struct packed {
      logic de;
      logic hsync;
      logic vsync;
   } sync_t;

   // 8x8 unsigned product widened to 16 bits so the luma sum cannot wrap
   function automatic logic [15:0] weight(input logic [7:0] comp, input logic [7:0] coef);
      return {8'd0, comp} * {8'd0, coef};
   endfunction

endpackage

// File: rtl/rgb_to_gray_stage_sync_delay.sv
// Parameterised shift register for the DE/HSYNC/VSYNC bundle; DEPTH = 0
// degenerates to a plain wire.
module sync_delay #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign o_q = i_d;
      end else begin : g_pipe
         logic [WIDTH-1:0] r_sr [DEPTH];

         // Shift one tap per clock, cleared by the synchronous reset
         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               for (int k = 0; k < DEPTH; k++) begin
                  r_sr[k] <= '0;
               end
            end else begin
               r_sr[0] <= i_d;
               for (int k = 1; k < DEPTH; k++) begin
                  r_sr[k] <= r_sr[k-1];
               end
            end
         end

         assign o_q = r_sr[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/rgb_to_gray_stage.sv
// Two-stage RGB -> 8-bit luma pipeline driving the LUT address, with syncs
// re-aligned to the LUT output and per-frame min/max luma statistics.
module rgb_to_gray_stage
   import rgb_to_gray_pkg::*;
#(
   parameter int   LUT_LATENCY = 1,
   parameter logic VSYNC_POL   = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_r,
   input  logic [7:0] in_g,
   input  logic [7:0] in_b,
   input  logic       in_de,
   input  logic       in_hsync,
   input  logic       in_vsync,
   output logic [7:0] lut_a,
   output logic       out_de,
   output logic       out_hsync,
   output logic       out_vsync,
   output logic [7:0] frame_min,
   output logic [7:0] frame_max,
   output logic       stats_valid
);

   logic [15:0] r_p_r;
   logic [15:0] r_p_g;
   logic [15:0] r_p_b;
   logic        r_de1;
   logic        r_vs1;
   logic        r_vs2;
   logic [7:0]  r_lut_a;
   logic [7:0]  r_run_min;
   logic [7:0]  r_run_max;
   logic [7:0]  r_frame_min;
   logic [7:0]  r_frame_max;
   logic        r_stats_valid;

   logic [7:0]  w_luma;
   logic [7:0]  w_min_nx;
   logic [7:0]  w_max_nx;
   logic        w_boundary;
   sync_t       w_sync_in;
   sync_t       w_sync_out;

   // Stage 1: weighted colour components plus the DE/VSYNC bits they belong to
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_p_r <= 16'd0;
         r_p_g <= 16'd0;
         r_p_b <= 16'd0;
         r_de1 <= 1'b0;
         r_vs1 <= 1'b0;
      end else begin
         r_p_r <= weight(in_r, COEF_R);
         r_p_g <= weight(in_g, COEF_G);
         r_p_b <= weight(in_b, COEF_B);
         r_de1 <= in_de;
         r_vs1 <= in_vsync;
      end
   end

   // Stats are evaluated on the values being loaded into stage 2, so a boundary
   // pulse lands in the same cycle as the lut_a of the pixel it includes.
   always_comb begin
      w_luma     = 8'd0;
      w_min_nx   = r_run_min;
      w_max_nx   = r_run_max;
      w_boundary = 1'b0;
      if (r_de1) begin
         w_luma = 8'((r_p_r + r_p_g + r_p_b + ROUND) >> 4'd8);
      end else begin
         w_luma = 8'd0;
      end
      if (r_de1 && (w_luma < r_run_min)) begin
         w_min_nx = w_luma;
      end else begin
         w_min_nx = r_run_min;
      end
      if (r_de1 && (w_luma > r_run_max)) begin
         w_max_nx = w_luma;
      end else begin
         w_max_nx = r_run_max;
      end
      w_boundary = (r_vs1 == VSYNC_POL) && (r_vs2 != VSYNC_POL);
   end

   // Stage 2: luma register and the VSYNC history used for edge detection
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lut_a <= 8'd0;
         r_vs2   <= 1'b0;
      end else begin
         r_lut_a <= w_luma;
         r_vs2   <= r_vs1;
      end
   end

   // Running and per-frame min/max; the running pair restarts at each boundary
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_run_min     <= 8'd255;
         r_run_max     <= 8'd0;
         r_frame_min   <= 8'd0;
         r_frame_max   <= 8'd0;
         r_stats_valid <= 1'b0;
      end else begin
         r_stats_valid <= w_boundary;
         if (w_boundary) begin
            r_frame_min <= w_min_nx;
            r_frame_max <= w_max_nx;
            r_run_min   <= 8'd255;
            r_run_max   <= 8'd0;
         end else begin
            r_run_min   <= w_min_nx;
            r_run_max   <= w_max_nx;
         end
      end
   end

   assign w_sync_in = {in_de, in_hsync, in_vsync};

   sync_delay #(
      .WIDTH ($bits(sync_t)),
      .DEPTH (PIPE_DEPTH + LUT_LATENCY)
   ) u_out_delay (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_d     (w_sync_in),
      .o_q     (w_sync_out)
   );

   assign lut_a       = r_lut_a;
   assign out_de      = w_sync_out.de;
   assign out_hsync   = w_sync_out.hsync;
   assign out_vsync   = w_sync_out.vsync;
   assign frame_min   = r_frame_min;
   assign frame_max   = r_frame_max;
   assign stats_valid = r_stats_valid;

endmodule

// File: tb/tb_rgb_to_gray_stage.sv
// Bench for rgb_to_gray_stage: three instances (latency 1, 0 and 3, the last
// with active-low VSYNC) checked every cycle against an input-history model.
module tb_rgb_to_gray_stage;

   localparam int NH = 8192;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic [7:0] in_r      = 8'd0;
   logic [7:0] in_g      = 8'd0;
   logic [7:0] in_b      = 8'd0;
   logic       in_de     = 1'b0;
   logic       in_hsync  = 1'b0;
   logic       in_vsync  = 1'b0;
   logic       in_vsync_n;

   logic [7:0] o_lut  [3];
   logic [7:0] o_fmin [3];
   logic [7:0] o_fmax [3];
   logic       o_de   [3];
   logic       o_hs   [3];
   logic       o_vs   [3];
   logic       o_sv   [3];

   int n_vec    = 0;
   int n_chk    = 0;
   int n_err    = 0;
   int edge_n   = -1;
   int last_rst = -1;
   int sv_cnt   = 0;

   logic [7:0] h_r  [NH];
   logic [7:0] h_g  [NH];
   logic [7:0] h_b  [NH];
   logic       h_de [NH];
   logic       h_hs [NH];
   logic       h_vs [NH];

   int run_min [2];
   int run_max [2];
   int e_fmin  [2];
   int e_fmax  [2];
   int e_sv    [2];

   assign in_vsync_n = ~in_vsync;

   always #5 clk = ~clk;

   rgb_to_gray_stage #(.LUT_LATENCY(1), .VSYNC_POL(1'b1)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n), .in_r(in_r), .in_g(in_g), .in_b(in_b),
      .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
      .lut_a(o_lut[0]), .out_de(o_de[0]), .out_hsync(o_hs[0]), .out_vsync(o_vs[0]),
      .frame_min(o_fmin[0]), .frame_max(o_fmax[0]), .stats_valid(o_sv[0]));

   rgb_to_gray_stage #(.LUT_LATENCY(0), .VSYNC_POL(1'b1)) u_dut_l0 (
      .clk(clk), .rst_n(rst_n), .in_r(in_r), .in_g(in_g), .in_b(in_b),
      .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
      .lut_a(o_lut[1]), .out_de(o_de[1]), .out_hsync(o_hs[1]), .out_vsync(o_vs[1]),
      .frame_min(o_fmin[1]), .frame_max(o_fmax[1]), .stats_valid(o_sv[1]));

   rgb_to_gray_stage #(.LUT_LATENCY(3), .VSYNC_POL(1'b0)) u_dut_l3 (
      .clk(clk), .rst_n(rst_n), .in_r(in_r), .in_g(in_g), .in_b(in_b),
      .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync_n),
      .lut_a(o_lut[2]), .out_de(o_de[2]), .out_hsync(o_hs[2]), .out_vsync(o_vs[2]),
      .frame_min(o_fmin[2]), .frame_max(o_fmax[2]), .stats_valid(o_sv[2]));

   function automatic int lat_of(input int i);
      case (i)
         0:       return 1;
         1:       return 0;
         default: return 3;
      endcase
   endfunction

   // Input sampled at edge idx still lives in the pipe (not lost to a reset)
   function automatic bit alive(input int idx);
      return (idx >= 0) && (idx > last_rst);
   endfunction

   function automatic int de_at(input int idx);
      if (!alive(idx)) return 0;
      return int'(h_de[idx]);
   endfunction

   function automatic int hs_at(input int idx);
      if (!alive(idx)) return 0;
      return int'(h_hs[idx]);
   endfunction

   // VSYNC level as seen on the instance pin: view 1 is the inverted feed
   function automatic int vs_at(input int idx, input int view);
      if (!alive(idx)) return 0;
      return int'(h_vs[idx]) ^ view;
   endfunction

   function automatic bit vs_active(input int raw, input int view);
      return (view == 0) ? (raw == 1) : (raw == 0);
   endfunction

   function automatic int luma_at(input int idx);
      if (de_at(idx) == 0) return 0;
      return (77 * int'(h_r[idx]) + 150 * int'(h_g[idx]) + 29 * int'(h_b[idx]) + 128) / 256;
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input int exp);
      n_chk++;
      assert (got === 16'(exp)) else begin
         n_err++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int r, input int g, input int b,
                       input logic de, input logic hs, input logic vs, input logic rst);
      int k;
      @(negedge clk);
      in_r     = 8'(r);
      in_g     = 8'(g);
      in_b     = 8'(b);
      in_de    = de;
      in_hsync = hs;
      in_vsync = vs;
      rst_n    = ~rst;
      @(posedge clk);
      edge_n++;
      k = edge_n;
      if (k >= NH) begin
         $display("FAIL history: edge budget %0d exhausted", NH);
         $fatal(1, "history overflow");
      end
      h_r[k]  = 8'(r);
      h_g[k]  = 8'(g);
      h_b[k]  = 8'(b);
      h_de[k] = de;
      h_hs[k] = hs;
      h_vs[k] = vs;
      if (rst) last_rst = k;
      for (int v = 0; v < 2; v++) begin
         if (rst) begin
            run_min[v] = 255;
            run_max[v] = 0;
            e_fmin[v]  = 0;
            e_fmax[v]  = 0;
            e_sv[v]    = 0;
         end else begin
            int mn;
            int mx;
            mn = run_min[v];
            mx = run_max[v];
            if (de_at(k-1) == 1) begin
               if (luma_at(k-1) < mn) mn = luma_at(k-1);
               if (luma_at(k-1) > mx) mx = luma_at(k-1);
            end
            if (vs_active(vs_at(k-1, v), v) && !vs_active(vs_at(k-2, v), v)) begin
               e_fmin[v]  = mn;
               e_fmax[v]  = mx;
               e_sv[v]    = 1;
               run_min[v] = 255;
               run_max[v] = 0;
            end else begin
               e_sv[v]    = 0;
               run_min[v] = mn;
               run_max[v] = mx;
            end
         end
      end
      #1;
      for (int i = 0; i < 3; i++) begin
         int v;
         int d;
         v = (i == 2) ? 1 : 0;
         d = k - 1 - lat_of(i);
         chk($sformatf("lut_a[%0d]@%0d", i, k), 16'(o_lut[i]), luma_at(k-1));
         chk($sformatf("out_de[%0d]@%0d", i, k), 16'(o_de[i]), de_at(d));
         chk($sformatf("out_hsync[%0d]@%0d", i, k), 16'(o_hs[i]), hs_at(d));
         chk($sformatf("out_vsync[%0d]@%0d", i, k), 16'(o_vs[i]), vs_at(d, v));
         chk($sformatf("stats_valid[%0d]@%0d", i, k), 16'(o_sv[i]), e_sv[v]);
         chk($sformatf("frame_min[%0d]@%0d", i, k), 16'(o_fmin[i]), e_fmin[v]);
         chk($sformatf("frame_max[%0d]@%0d", i, k), 16'(o_fmax[i]), e_fmax[v]);
      end
      if (o_sv[0] === 1'b1) sv_cnt++;
      n_vec++;
   endtask

   task automatic idle(input logic vs);
      step(0, 0, 0, 1'b0, 1'b0, vs, 1'b0);
   endtask

   // Directed pixel: its luma shows up on lut_a two cycles later
   task automatic pix_check(input string tag, input int r, input int g, input int b, input int exp);
      step(r, g, b, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      chk(tag, 16'(o_lut[0]), exp);
   endtask

   initial begin
      for (int n = 0; n < 3; n++) step(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("reset_lut_a", 16'(o_lut[0]), 0);
      chk("reset_frame_min", 16'(o_fmin[0]), 0);
      idle(1'b0);

      // White: luma 255 at t+2, out_de at t+3 on the latency-1 instance
      step(255, 255, 255, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      chk("white_lut", 16'(o_lut[0]), 255);
      idle(1'b0);
      chk("white_out_de", 16'(o_de[0]), 1);

      pix_check("red",   255, 0,   0,   77);
      pix_check("green", 0,   255, 0,   149);
      pix_check("blue",  0,   0,   255, 29);
      pix_check("grey",  128, 128, 128, 128);
      step(200, 200, 200, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      chk("de0_lut", 16'(o_lut[0]), 0);

      // Sync pulse train; alignment for every latency is checked per cycle
      step(10, 20, 30, 1'b1, 1'b1, 1'b0, 1'b0);
      step(40, 50, 60, 1'b0, 1'b1, 1'b1, 1'b0);
      step(70, 80, 90, 1'b1, 1'b0, 1'b1, 1'b0);
      step(0,  0,  0,  1'b0, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 6; n++) idle(1'b0);

      // Frame with grey pixels 10, 200, 57
      idle(1'b1); idle(1'b1); idle(1'b0);
      step(10, 10, 10, 1'b1, 1'b0, 1'b0, 1'b0);
      step(200, 200, 200, 1'b1, 1'b0, 1'b0, 1'b0);
      step(57, 57, 57, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1'b0); idle(1'b0);
      idle(1'b1);
      chk("frame_sv_early", 16'(o_sv[0]), 0);
      idle(1'b1);
      chk("frame_sv", 16'(o_sv[0]), 1);
      chk("frame_min", 16'(o_fmin[0]), 10);
      chk("frame_max", 16'(o_fmax[0]), 200);
      chk("frame_min_pol0", 16'(o_fmin[2]), 10);
      idle(1'b1);
      chk("frame_sv_one_cycle", 16'(o_sv[0]), 0);

      // Frame with no active pixels
      idle(1'b0); idle(1'b0); idle(1'b0);
      idle(1'b1); idle(1'b1);
      chk("empty_sv", 16'(o_sv[0]), 1);
      chk("empty_min", 16'(o_fmin[0]), 255);
      chk("empty_max", 16'(o_fmax[0]), 0);

      // Reset mid-frame after pixel 5; only 100 and 120 survive
      idle(1'b0); idle(1'b0);
      step(5, 5, 5, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      step(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_lut_a", 16'(o_lut[0]), 0);
      chk("rst_frame_min", 16'(o_fmin[0]), 0);
      chk("rst_frame_max", 16'(o_fmax[0]), 0);
      step(100, 100, 100, 1'b1, 1'b0, 1'b0, 1'b0);
      step(120, 120, 120, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b1); idle(1'b1);
      chk("post_rst_sv", 16'(o_sv[0]), 1);
      chk("post_rst_min", 16'(o_fmin[0]), 100);
      chk("post_rst_max", 16'(o_fmax[0]), 120);
      chk("post_rst_max_pol0", 16'(o_fmax[2]), 120);

      // Back-to-back boundaries, VSYNC toggling every 2 cycles
      idle(1'b0); idle(1'b0); idle(1'b0);
      sv_cnt = 0;
      for (int n = 0; n < 4; n++) begin
         step(30 * n, 60, 90, 1'b1, 1'b0, 1'b1, 1'b0);
         idle(1'b1);
         idle(1'b0);
         idle(1'b0);
      end
      chk("b2b_pulses", 16'(sv_cnt), 4);

      // Randomised traffic with periodic frames and rare resets
      for (int n = 0; n < 2000; n++) begin
         step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'(((n % 97) < 3) || ((n % 211) == 5)),
              1'($urandom_range(0, 699) == 0));
      end

      $display("comparisons made: %0d", n_chk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rgb_to_gray_stage.md
Name: rgb_to_gray_stage

Overview:
- Upstream neighbour of the binarisation LUT in the HDMI video path.
- Converts each incoming 24-bit RGB pixel to 8-bit luma through a 2-stage pipeline and drives the result onto the LUT address bus.
- Delays DE/HSYNC/VSYNC so they line up with the LUT's registered output.
- Gathers per-frame min/max luma statistics that software uses to choose the threshold table.

Parameters:
- LUT_LATENCY, 1, clock cycles between the LUT address and its registered output (qspo). Range 0..4.
- VSYNC_POL, 1, active level of in_vsync (1 = active-high, 0 = active-low).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous reset, active-low
- in_r  in  8  red component
- in_g  in  8  green component
- in_b  in  8  blue component
- in_de  in  1  data enable (active pixel)
- in_hsync  in  1  horizontal sync, passed through unchanged
- in_vsync  in  1  vertical sync
- lut_a  out  8  luma, connects to the LUT address input
- out_de  out  1  in_de delayed by 2+LUT_LATENCY cycles
- out_hsync  out  1  in_hsync delayed by 2+LUT_LATENCY cycles
- out_vsync  out  1  in_vsync delayed by 2+LUT_LATENCY cycles
- frame_min  out  8  minimum active luma of the last completed frame
- frame_max  out  8  maximum active luma of the last completed frame
- stats_valid  out  1  one-cycle pulse when frame_min/frame_max update

Behaviour:
- Single clock domain. rst_n is sampled on the rising edge of clk only.
- Reset values:
  - lut_a, out_de, out_hsync, out_vsync, frame_min, frame_max, stats_valid = 0.
  - All pipeline and delay registers = 0.
  - Running min = 255, running max = 0.
- Stage 1 (registered): p_r = 77*R, p_g = 150*G, p_b = 29*B, each 16 bits unsigned. The DE/sync bits are registered alongside.
- Stage 2 (registered):
  - s = p_r + p_g + p_b + 128, 16 bits unsigned. Maximum value is 65408, so there is no overflow.
  - lut_a = s[15:8], i.e. round-half-up.
  - When stage-1 DE = 0, lut_a is forced to 0.
- Latency:
  - lut_a is valid 2 cycles after the input pixel.
  - out_* are valid 2+LUT_LATENCY cycles after the input, aligned with qspo.
  - HSYNC is never inspected; it is delayed only.
- Statistics run on the stage-2 aligned signals (lut_a, de2, vsync2):
  - Each cycle with de2 = 1: running min = min(running min, lut_a); running max = max(running max, lut_a).
  - A frame boundary is the transition of vsync2 from inactive to active, with polarity set by VSYNC_POL.
  - On a boundary cycle:
    - frame_min/frame_max are loaded from the running values, including a pixel with de2 = 1 in that same cycle.
    - stats_valid = 1 for exactly that cycle.
    - Running min/max return to 255/0.
- Frame with no active pixels: frame_min = 255, frame_max = 0, and stats_valid still pulses.
- Before the first boundary after reset, frame_min/frame_max hold 0 and stats_valid stays 0.
- Reset asserted mid-frame: pipeline and stats are discarded. The first stats_valid after reset covers only pixels received after reset.
- Back-to-back boundaries (VSYNC toggling every 2 cycles): each rising edge produces its own pulse.
- No back-pressure: the block accepts one pixel per clock, always.

Decomposition:
- Package rgb_to_gray_pkg holds:
  - COEF_R = 77, COEF_G = 150, COEF_B = 29 (sum 256), ROUND = 128, PIPE_DEPTH = 2.
  - A 3-bit sync-bundle typedef {de, hsync, vsync}.
- Sub-module sync_delay: a parameterised shift register (WIDTH, DEPTH, with DEPTH = 0 meaning a wire) using the same synchronous active-low reset. It is instantiated for the 3-bit sync bundle with DEPTH = 2+LUT_LATENCY.
- Stage-2 sync tap: a second instance with DEPTH = 2, or a tap on the first instance.

Test Plan:
- White (255,255,255), DE = 1 at cycle t → lut_a = 255 at t+2; out_de = 1 at t+3 (LUT_LATENCY = 1).
- Pure red (255,0,0) → lut_a = 77. Pure green (0,255,0) → 149. Pure blue (0,0,255) → 29. Grey (128,128,128) → 128.
- Pixel (200,200,200) with in_de = 0 → lut_a = 0. DE/HSYNC/VSYNC pulse pattern appears on out_* shifted exactly 3 cycles; repeat with LUT_LATENCY = 0 (shift 2) and LUT_LATENCY = 3 (shift 5).
- Frame with active grey pixels 10, 200, 57, then VSYNC rising → frame_min = 10, frame_max = 200, stats_valid high for exactly 1 cycle, 2 cycles after the input VSYNC edge.
- Frame with DE never high between two VSYNC edges → frame_min = 255, frame_max = 0, stats_valid pulses once.
- rst_n low for 1 cycle mid-frame after pixel 5 (min 5), then pixels 100 and 120, then VSYNC → all outputs 0 during reset; stats report min = 100, max = 120.
